// File: rtl/acc_pkg.sv
// acc_pkg: shared types and default sizes for the accumulator sequencer.
//   state_e       - sequencer FSM states (IDLE, RUN, DONE)
//   DEF_WIDTH     - default datapath width, matches the ripple adder
//   DEF_LEN_W     - default batch-length field width
package acc_pkg;

    localparam int unsigned DEF_WIDTH = 6;
    localparam int unsigned DEF_LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : acc_pkg

// File: rtl/acc_beat_cnt.sv
// acc_beat_cnt: loadable down-counter tracking operands left in a batch.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load_i    - load len_i into the counter (has priority over dec_i)
//   len_i     - batch length to load
//   dec_i     - decrement by one (saturates at zero)
//   last_o    - registered flag, high while count == 1
module acc_beat_cnt
    import acc_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;
    logic             last_q;

    // Next count: load wins over decrement; never wrap below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = len_i;
        end else if (dec_i && (count_q != LEN_W'(0))) begin
            count_d = count_q - LEN_W'(1);
        end
    end

    // last is registered from the next count so it is valid with the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= LEN_W'(0);
            last_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= (count_d == LEN_W'(1));
        end
    end

    assign last_o = last_q;

endmodule : acc_beat_cnt

// File: rtl/acc_sequencer.sv
// acc_sequencer: control and register stage around the external 6-bit
// combinational ripple adder. Accepts a batch of operands, accumulates them
// through the adder, and presents the total plus a sticky overflow flag.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   start, len           - begin a batch of len operands (sampled in IDLE)
//   in_valid/in_ready    - operand stream handshake, operand on in_data
//   add_a, add_b         - adder operands (acc, in_data)
//   add_sum              - adder result, add_a + add_b mod 2^WIDTH
//   out_valid/out_ready  - result handshake, total on out_data
//   ovf                  - sticky unsigned overflow for the batch
//   busy                 - high whenever the FSM is not in IDLE
module acc_sequencer
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             ovf,
    output logic             busy
);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             load;
    logic             accept;
    logic             last;

    // in_ready_q is only ever high in RUN, so it alone qualifies an accept.
    assign accept = in_ready_q && in_valid;
    assign load   = (state_q == IDLE) && start && (len != LEN_W'(0));

    acc_beat_cnt #(
        .LEN_W (LEN_W)
    ) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .len_i  (len),
        .dec_i  (accept),
        .last_o (last)
    );

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= WIDTH'(0);
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q  <= WIDTH'(0);
                        ovf_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len != LEN_W'(0)) begin
                            state_q    <= RUN;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        acc_q <= add_sum;
                        // A modular sum below the old total means the add wrapped.
                        ovf_q <= ovf_q | (add_sum < acc_q);
                        if (last) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;
    assign out_data  = acc_q;
    assign add_a     = acc_q;
    assign add_b     = in_data;

endmodule : acc_sequencer

// File: tb/tb_acc_sequencer.sv
// tb_acc_sequencer: directed self-checking bench for acc_sequencer with a
// behavioural model of the external 6-bit adder.
module tb_acc_sequencer;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned LEN_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             ovf;
    logic             busy;

    int checks;
    int errors;

    acc_sequencer #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ovf       (ovf),
        .busy      (busy)
    );

    // External combinational adder, modulo 2^WIDTH.
    assign add_sum = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        step();
        start = 1'b0;
    endtask

    task automatic beat(input int v);
        in_valid = 1'b1;
        in_data  = WIDTH'(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();

        // Reset state.
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_add_a", 32'(add_a), 0);
        check("rst_ovf", 32'(ovf), 0);
        rst = 1'b0;
        step();

        // len=3: 5+10+20 = 35, no overflow.
        do_start(3);
        check("b1_in_ready", 32'(in_ready), 1);
        check("b1_busy", 32'(busy), 1);
        in_data = WIDTH'(17);
        #1;
        check("b1_add_b", 32'(add_b), 17);
        beat(5);
        beat(10);
        check("b1_add_a_mid", 32'(add_a), 15);
        check("b1_no_early_valid", 32'(out_valid), 0);
        beat(20);
        check("b1_out_valid", 32'(out_valid), 1);
        check("b1_out_data", 32'(out_data), 35);
        check("b1_ovf", 32'(ovf), 0);
        check("b1_in_ready_low", 32'(in_ready), 0);
        handshake();
        check("b1_post_valid", 32'(out_valid), 0);
        check("b1_post_busy", 32'(busy), 0);

        // len=2: 40+30 = 70 mod 64 = 6, overflow.
        do_start(2);
        beat(40);
        check("b2_ovf_first", 32'(ovf), 0);
        beat(30);
        check("b2_out_data", 32'(out_data), 6);
        check("b2_ovf", 32'(ovf), 1);
        handshake();

        // len=3: 63+1+0 = 0, overflow stays sticky through the +0.
        do_start(3);
        check("b3_ovf_cleared", 32'(ovf), 0);
        beat(63);
        beat(1);
        check("b3_ovf_wrap", 32'(ovf), 1);
        beat(0);
        check("b3_out_data", 32'(out_data), 0);
        check("b3_ovf", 32'(ovf), 1);
        check("b3_out_valid", 32'(out_valid), 1);
        handshake();

        // len=0: straight to DONE, ovf from previous batch cleared.
        do_start(0);
        check("b4_out_valid", 32'(out_valid), 1);
        check("b4_in_ready", 32'(in_ready), 0);
        check("b4_out_data", 32'(out_data), 0);
        check("b4_ovf", 32'(ovf), 0);
        check("b4_busy", 32'(busy), 1);
        handshake();
        check("b4_post_busy", 32'(busy), 0);

        // len=4 with 2-cycle gaps and a 3-cycle output stall.
        do_start(4);
        for (int i = 1; i <= 4; i++) begin
            beat(i);
            if (i < 4) begin
                in_data = WIDTH'(50);
                step();
                step();
                check("b5_gap_in_ready", 32'(in_ready), 1);
                check("b5_gap_hold", 32'(add_a), 32'((i * (i + 1)) / 2));
            end
        end
        for (int i = 0; i < 3; i++) begin
            check("b5_stall_valid", 32'(out_valid), 1);
            check("b5_stall_data", 32'(out_data), 10);
            step();
        end
        // start during the handshake must be ignored.
        start     = 1'b1;
        len       = LEN_W'(5);
        out_ready = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        check("b5_post_busy", 32'(busy), 0);
        check("b5_post_valid", 32'(out_valid), 0);
        step();
        check("b5_start_ignored", 32'(busy), 0);
        check("b5_start_ignored_rdy", 32'(in_ready), 0);

        // start with len=7 during RUN is ignored; batch keeps len=2.
        do_start(2);
        start = 1'b1;
        len   = LEN_W'(7);
        beat(3);
        start = 1'b0;
        beat(4);
        check("b6_out_valid", 32'(out_valid), 1);
        check("b6_out_data", 32'(out_data), 7);
        handshake();

        // Reset after 2 of 5 beats aborts the batch.
        do_start(5);
        beat(4);
        beat(5);
        check("b7_acc_before_rst", 32'(add_a), 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("b7_in_ready", 32'(in_ready), 0);
        check("b7_busy", 32'(busy), 0);
        check("b7_out_data", 32'(out_data), 0);
        check("b7_ovf", 32'(ovf), 0);
        check("b7_out_valid", 32'(out_valid), 0);
        in_valid = 1'b1;
        in_data  = WIDTH'(6);
        for (int i = 0; i < 6; i++) begin
            step();
            check("b7_no_out_valid", 32'(out_valid), 0);
            check("b7_no_accept", 32'(out_data), 0);
        end
        in_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_acc_sequencer

// File: doc/acc_sequencer.md
# acc_sequencer

Control and register stage wrapped around the 6-bit combinational ripple adder in the accumulator datapath. Accepts a batch of operands over a valid/ready stream and drives the accumulator value and each operand into the adder. Latches the adder's sum back into the accumulator register. Presents the final total, with a sticky unsigned-overflow flag, on an output handshake.

## Interface

Parameters:
- WIDTH, 6, datapath width; must match the adder width.
- LEN_W, 4, width of the batch-length field; maximum batch is 2^LEN_W − 1 operands.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a batch; sampled only in IDLE.
- len  input  LEN_W  operand count for the batch; sampled with start.
- in_valid  input  1  operand present.
- in_data  input  WIDTH  operand.
- in_ready  output  1  operand accepted when in_valid && in_ready.
- add_a  output  WIDTH  to adder operand 1; always equals acc.
- add_b  output  WIDTH  to adder operand 2; always equals in_data.
- add_sum  input  WIDTH  from adder; combinational add_a + add_b mod 2^WIDTH.
- out_valid  output  1  result available.
- out_data  output  WIDTH  accumulated total; equals acc.
- out_ready  input  1  result consumed when out_valid && out_ready.
- ovf  output  1  sticky: some accepted add wrapped past 2^WIDTH − 1.
- busy  output  1  high in any state other than IDLE.

## Operation

FSM states: IDLE, RUN, DONE.

IDLE:
- in_ready = 0; out_valid = 0.
- On start, with len ≠ 0: clear acc, clear ovf, load remaining counter with len, go to RUN.
- On start, with len = 0: clear acc, clear ovf, go directly to DONE.

RUN:
- in_ready = 1.
- Each accepted beat: acc ← add_sum; ovf ← ovf | (add_sum < acc), unsigned compare; remaining ← remaining − 1.
- The beat accepted while remaining = 1 moves the FSM to DONE.
- Cycles with in_valid = 0 change nothing.

DONE:
- out_valid = 1.
- out_data and ovf are held stable while out_ready = 0.
- On out_ready, go to IDLE. acc and ovf keep their values until the next start.

General rules:
- start is ignored while busy.
- len is sampled only on the start cycle.
- The adder carry-out is not used. Arithmetic is modulo 2^WIDTH; overflow is detected only by the sum < acc compare.

## Timing

- Reset values: state = IDLE; acc = 0; remaining = 0; ovf = 0; in_ready = 0; out_valid = 0; busy = 0; out_data = 0; add_a = 0.
- Reset asserted mid-batch aborts the batch within one cycle. No out_valid is produced for the aborted batch.
- Throughput: one operand per cycle in RUN. The adder path add_a/add_b → add_sum is combinational within the cycle.
- Latency, start to RUN: 1 cycle. in_ready rises in the cycle after start.
- Latency, last beat to out_valid: 1 cycle.
- out_valid rises in the cycle after the last accept and stays high until a cycle with out_ready = 1.
- A batch of N operands with no stalls takes N + 2 cycles, counted from start to the out_valid && out_ready handshake (out_ready held high).
- start asserted in the same cycle as the DONE handshake is ignored. start must be re-presented in IDLE.

## Structure

- Shared package acc_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - default WIDTH = 6 and LEN_W = 4 constants.
- One natural sub-module: acc_beat_cnt.
  - Loadable LEN_W-bit down-counter with load, dec and last (count == 1) outputs.
- The adder is not instantiated inside this block. It is connected at the accumulator top level through add_a, add_b and add_sum.

## Test plan

- start, len = 3; operands 5, 10, 20 back-to-back → out_data = 35, ovf = 0, out_valid 1 cycle after the third accept.
- start, len = 2; operands 40, 30 → out_data = 6 (70 mod 64), ovf = 1. Also: 63, 1, 0 with len = 3 → out_data = 0, ovf = 1.
- start, len = 0 → DONE in 1 cycle, out_data = 0, ovf = 0, no in_ready pulse.
- len = 4; operands 1, 2, 3, 4 with 2-cycle in_valid gaps; out_ready low for 3 cycles → out_data = 10 held stable until out_ready; busy low the cycle after the handshake.
- start pulsed during RUN with len = 7 → ignored; batch completes with its original len.
- rst asserted after 2 of 5 beats (acc = 9) → next cycle: state IDLE, acc = 0, ovf = 0, in_ready = 0, out_valid never asserted for that batch.
